// File: rtl/pt20_trit_unpacker.sv
// pt20_trit_unpacker: iterative decoder for PT-20 packed words.
// A 32-bit word holding 20 balanced trits in base 3 is accepted on a
// valid/ready handshake. TRITS_PER_CYCLE digits are peeled off per cycle, and
// the 20 trits are presented as 2-bit codes (00=0, 01=+1, 10=-1).
//
// Ports:
//   clk      - rising-edge clock
//   reset_n  - asynchronous active-low reset
//   s_valid  - input word valid
//   s_ready  - unpacker can take s_word this cycle (combinational)
//   s_word   - packed PT-20 word
//   m_valid  - decoded trits valid
//   m_ready  - downstream accepts m_trits this cycle
//   m_trits  - trit i at bits [2i+1:2i], trit 0 = least-significant digit
//   m_err    - word was >= 3^20 (m_trits forced to zero), qualified by m_valid
//   busy     - high while decoding
module pt20_trit_unpacker #(
    parameter int unsigned TRITS_PER_CYCLE = 1,
    parameter int unsigned TRITS_PER_WORD  = 20
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic [31:0] s_word,
    output logic        m_valid,
    input  logic        m_ready,
    output logic [39:0] m_trits,
    output logic        m_err,
    output logic        busy
);

    localparam int unsigned TPC   = TRITS_PER_CYCLE;
    localparam int unsigned TW    = 2 * TRITS_PER_WORD;
    localparam int unsigned CW    = 2 * TPC;
    localparam int unsigned CNT_W = 5;

    localparam logic [CNT_W-1:0] CNT_STEP  = CNT_W'(TPC);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(TRITS_PER_WORD - TPC);
    localparam logic [31:0]      MAX_LEGAL = 32'd3486784400;

    // Reject throughputs that do not divide the word evenly.
    generate
        if (!(TPC inside {1, 2, 4, 5, 10, 20}) || TRITS_PER_WORD != 20) begin : g_bad_param
            $error("pt20_trit_unpacker: TRITS_PER_CYCLE must divide 20 and TRITS_PER_WORD must be 20");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, DECODE, HOLD} state_t;

    state_t           state;
    logic [31:0]      rem;
    logic [CNT_W-1:0] cnt;
    logic             err;

    logic [31:0]      rem_next;
    logic [CW-1:0]    chunk;
    logic [TW-1:0]    trits_shift;
    logic             accept;

    assign s_ready = (state == IDLE) || ((state == HOLD) && m_ready);
    assign accept  = s_valid && s_ready;

    // Peel TPC base-3 digits off the remainder, least significant first.
    always_comb begin
        logic [31:0] r;
        r     = rem;
        chunk = '0;
        for (int k = 0; k < int'(TPC); k++) begin
            case (r % 32'd3)
                32'd0:   chunk[2*k +: 2] = 2'b10;
                32'd1:   chunk[2*k +: 2] = 2'b00;
                default: chunk[2*k +: 2] = 2'b01;
            endcase
            r = r / 32'd3;
        end
        rem_next = r;
    end

    // New digits enter at the top and slide down; after 20/TPC cycles the
    // first digit extracted sits in slot 0.
    assign trits_shift = TW'({chunk, m_trits} >> CW);

    // Control FSM with registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            rem     <= '0;
            cnt     <= '0;
            err     <= 1'b0;
            m_valid <= 1'b0;
            m_err   <= 1'b0;
            m_trits <= '0;
            busy    <= 1'b0;
        end else begin
            if (accept) begin
                rem   <= s_word;
                cnt   <= '0;
                err   <= (s_word > MAX_LEGAL);
                busy  <= 1'b1;
                state <= DECODE;
            end
            case (state)
                IDLE: ;
                DECODE: begin
                    rem <= rem_next;
                    cnt <= cnt + CNT_STEP;
                    if (cnt == CNT_LAST) begin
                        m_trits <= err ? '0 : trits_shift;
                        m_err   <= err;
                        m_valid <= 1'b1;
                        busy    <= 1'b0;
                        state   <= HOLD;
                    end else begin
                        m_trits <= trits_shift;
                    end
                end
                HOLD: begin
                    if (m_ready) begin
                        m_valid <= 1'b0;
                        m_err   <= 1'b0;
                        if (!s_valid) begin
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
